// File: rtl/sram_vec_reader.sv
// -----------------------------------------------------------------------------
// sram_vec_reader
//   Read master for the SRAM arbiter's tr_* Avalon-MM slave port. A start
//   command fetches a contiguous block of words with pipelined reads. The
//   words are buffered in a small FIFO and handed to the test runner as a
//   valid/ready stream. The block absorbs the arbiter's fixed read latency and
//   any waitrequest stalls.
//
//   Optional feature: define SRAM_VEC_READER_CHECKSUM_EN to add a running
//   modulo-2^DATA_WIDTH checksum of every word delivered on the stream.
// -----------------------------------------------------------------------------
module sram_vec_reader #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  // command interface
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  // arbiter slave port
  output logic [ADDR_WIDTH-1:0] tr_address,
  output logic [BE_WIDTH-1:0]   tr_byteenable,
  output logic                  tr_read,
  output logic                  tr_write,
  output logic [DATA_WIDTH-1:0] tr_writedata,
  input  logic [DATA_WIDTH-1:0] tr_readdata,
  input  logic                  tr_readdataready,
  input  logic                  tr_waitrequest,
  // vector stream to the test runner
  output logic [DATA_WIDTH-1:0] vec_data,
  output logic                  vec_valid,
  input  logic                  vec_ready
`ifdef SRAM_VEC_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // FIFO depth expressed in the pointer/counter width and in the credit width
  // (one bit wider, since fifo_count + outstanding can reach 2*FIFO_DEPTH).
  localparam logic [FIFO_AW:0]   DEPTH_CNT    = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW+1:0] DEPTH_CREDIT = (FIFO_AW + 2)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q,       state_d;
  logic [ADDR_WIDTH-1:0] addr_q,        addr_d;
  logic [CNT_WIDTH-1:0]  remaining_q,   remaining_d;
  logic [FIFO_AW:0]      outstanding_q, outstanding_d;
  logic [FIFO_AW:0]      wr_ptr_q,      wr_ptr_d;
  logic [FIFO_AW:0]      rd_ptr_q,      rd_ptr_d;
  logic                  done_q,        done_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Derived control
  // ---------------------------------------------------------------------------
  logic [FIFO_AW:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [FIFO_AW+1:0] credit_used;
  logic               credit_ok;
  logic               in_active;    // FETCH or DRAIN: abort is honoured here
  logic               abort_take;   // abort accepted this cycle
  logic               start_take;   // start sampled in IDLE with a non-empty block
  logic               start_zero;   // start sampled in IDLE with word_count == 0
  logic               req_accept;   // read request accepted by the arbiter
  logic               rsp;          // a read word returns this cycle
  logic               discard;      // returning word is dropped (flush in progress)
  logic               fifo_wr;
  logic               fifo_rd;
  logic               drain_exit;
  logic               flush_exit;

  // Two-pointer FIFO with one extra wrap bit so full and empty are distinct.
  assign fifo_count  = wr_ptr_q - rd_ptr_q;
  assign fifo_empty  = (fifo_count == '0);
  assign fifo_full   = (fifo_count == DEPTH_CNT);

  // Every issued read owns a FIFO slot until it is consumed, so the FIFO can
  // never overflow regardless of how long the consumer stalls.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign credit_ok   = (credit_used < DEPTH_CREDIT);

  assign in_active   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign abort_take  = abort && in_active;
  assign start_take  = (state_q == ST_IDLE) && start && (word_count != '0);
  assign start_zero  = (state_q == ST_IDLE) && start && (word_count == '0);

  // tr_read depends only on registered state plus abort, so it cannot change
  // while waitrequest stalls the request: the credit sum can only shrink
  // without an acceptance.
  assign tr_read     = (state_q == ST_FETCH) && (remaining_q != '0) && credit_ok && !abort;
  assign req_accept  = tr_read && !tr_waitrequest;

  // The outstanding guard keeps a stray strobe from underflowing the counter.
  assign rsp         = tr_readdataready && (outstanding_q != '0);
  assign discard     = (state_q == ST_FLUSH) || abort_take;
  assign fifo_wr     = rsp && !discard;
  assign fifo_rd     = vec_valid && vec_ready;

  assign drain_exit  = (state_q == ST_DRAIN) && !abort && (outstanding_q == '0) && fifo_empty;
  assign flush_exit  = (state_q == ST_FLUSH) && (outstanding_q == '0);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q || drain_exit || flush_exit;
  assign tr_address    = addr_q;
  assign tr_byteenable = '1;
  assign tr_write      = 1'b0;
  assign tr_writedata  = '0;
  assign vec_valid     = !fifo_empty;
  // Gated so the head output reads zero whenever nothing is buffered.
  assign vec_data      = vec_valid ? mem_q[rd_ptr_q[FIFO_AW-1:0]] : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Request address and remaining-word count: load on start, step on accept.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    addr_d      = addr_q;
    remaining_d = remaining_q;
    if (start_take) begin
      addr_d      = base_addr;
      remaining_d = word_count;
    end else if (req_accept) begin
      addr_d      = addr_q + 1'b1;        // wraps modulo 2^ADDR_WIDTH
      remaining_d = remaining_q - 1'b1;
    end
  end

  // Reads in flight: up on accept, down on return, unchanged when both occur.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({req_accept, rsp})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // FIFO pointers: push returned words, pop on handshake, empty on abort.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (fifo_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (abort_take) rd_ptr_d = wr_ptr_d;
  end

  // Control FSM; done_q covers only the zero-length start, the other done
  // sources are decoded directly from the exiting state.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_take) state_d = ST_FETCH;
        done_d = start_zero;
      end
      ST_FETCH: begin
        if (abort)                                           state_d = ST_FLUSH;
        else if (req_accept && (remaining_q == CNT_WIDTH'(1))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)           state_d = ST_FLUSH;
        else if (drain_exit) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (flush_exit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Control and counter registers, asynchronously cleared.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      done_q        <= done_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; its contents are only visible
    // through vec_data, which is gated by the pointers that do reset.
    if (fifo_wr) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= tr_readdata;
  end

`ifdef SRAM_VEC_READER_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Stream checksum
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  // Clear on any start sampled in IDLE, accumulate every stream handshake.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == ST_IDLE) && start) checksum_d = '0;
    else if (fifo_rd)                  checksum_d = checksum_q + vec_data;
  end

  // Checksum register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

  // ---------------------------------------------------------------------------
  // Simulation checks
  // ---------------------------------------------------------------------------

  // A word that must be stored while the FIFO is full means the credit
  // accounting is broken.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(rsp && !discard && fifo_full));

endmodule

// File: tb/tb_sram_vec_reader.sv
// -----------------------------------------------------------------------------
// tb_sram_vec_reader
//   Drives sram_vec_reader against a behavioural arbiter (2-cycle read
//   latency, programmable waitrequest stall) and a scoreboard of the words
//   expected on the vector stream.
//   Timing inside a clock period (posedge at +5 after each negedge):
//     +0 tests drive inputs, +2 arbiter model, +3 stream monitor, +4 tests sample.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_vec_reader;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = DW / 8;
  localparam int CW = AW + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] tr_address;
  logic [BW-1:0] tr_byteenable;
  logic          tr_read;
  logic          tr_write;
  logic [DW-1:0] tr_writedata;
  logic [DW-1:0] tr_readdata = '0;
  logic          tr_readdataready = 1'b0;
  logic          tr_waitrequest = 1'b0;
  logic [DW-1:0] vec_data;
  logic          vec_valid;
  logic          vec_ready = 1'b0;
`ifdef SRAM_VEC_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  sram_vec_reader dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .base_addr        (base_addr),
    .word_count       (word_count),
    .busy             (busy),
    .done             (done),
    .tr_address       (tr_address),
    .tr_byteenable    (tr_byteenable),
    .tr_read          (tr_read),
    .tr_write         (tr_write),
    .tr_writedata     (tr_writedata),
    .tr_readdata      (tr_readdata),
    .tr_readdataready (tr_readdataready),
    .tr_waitrequest   (tr_waitrequest),
    .vec_data         (vec_data),
    .vec_valid        (vec_valid),
    .vec_ready        (vec_ready)
`ifdef SRAM_VEC_READER_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  always #5 clock = ~clock;

  // Bookkeeping
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            acc_count = 0;
  int            rsp_count = 0;
  int            hs_count = 0;
  int            first_acc_cyc = 0;
  int            last_acc_cyc = 0;
  int            first_hs_cyc = 0;
  int            last_hs_cyc = 0;
  int            start_cyc = 0;
  int            stall_left = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] last_acc_addr = '0;
  logic [DW-1:0] exp_q[$];

  // Arbiter model state
  logic [1:0]    pipe_v = '0;
  logic [AW-1:0] pipe_a0 = '0;
  logic [AW-1:0] pipe_a1 = '0;

  // SRAM contents: three fixed words for the checksum case, a pattern elsewhere.
  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    case (a)
      20'h00300: return 16'h0001;
      20'h00301: return 16'hFFFF;
      20'h00302: return 16'h0010;
      default:   return a[15:0] ^ 16'h5A3C;
    endcase
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural arbiter: stall control, acceptance check, 2-cycle return.
  always @(negedge clock) begin
    #2;
    if (reset) begin
      pipe_v           = '0;
      tr_readdataready = 1'b0;
      tr_readdata      = '0;
      tr_waitrequest   = 1'b0;
      stall_left       = 0;
    end else begin
      tr_waitrequest = (stall_left != 0);
      if (stall_left != 0) stall_left = stall_left - 1;
      tr_readdataready = pipe_v[1];
      tr_readdata      = pipe_v[1] ? sram_word(pipe_a1) : '0;
      if (pipe_v[1]) rsp_count++;
      pipe_v[1] = pipe_v[0];
      pipe_a1   = pipe_a0;
      pipe_v[0] = tr_read && !tr_waitrequest;
      pipe_a0   = tr_address;
      if (pipe_v[0]) begin
        n_checks++;
        if (tr_address !== exp_addr)
          $display("FAIL accept_addr: got %h expected %h", tr_address, exp_addr);
        else n_pass++;
        if (acc_count == 0) first_acc_cyc = cyc;
        last_acc_cyc  = cyc;
        last_acc_addr = tr_address;
        acc_count++;
        exp_addr = exp_addr + 1'b1;
      end
    end
  end

  // Stream monitor: every handshake pops and compares one expected word.
  always @(negedge clock) begin
    logic [DW-1:0] exp_w;
    #3;
    if (!reset && vec_valid && vec_ready) begin
      hs_count++;
      if (hs_count == 1) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_word: got %h expected none", vec_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (vec_data !== exp_w) $display("FAIL stream_word: got %h expected %h", vec_data, exp_w);
        else n_pass++;
      end
    end
  end

  // Pulse start for one cycle and queue the words the block should deliver.
  task automatic start_fetch(input logic [AW-1:0] b, input int c);
    logic [AW-1:0] a;
    @(negedge clock);
    base_addr  = b;
    word_count = CW'(c);
    start      = 1'b1;
    exp_addr   = b;
    acc_count  = 0;
    rsp_count  = 0;
    hs_count   = 0;
    start_cyc  = cyc;
    a = b;
    for (int i = 0; i < c; i++) begin
      exp_q.push_back(sram_word(a));
      a = a + 1'b1;
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then confirm it was a single-cycle pulse and busy fell.
  task automatic finish_fetch(input string name, input int budget, output int done_cyc);
    bit got = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock); #4;
      if (done === 1'b1) begin
        got = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    n_checks++;
    if (!got) $display("FAIL %s_done_timeout: got no done expected done within %0d cycles", name, budget);
    else n_pass++;
    @(negedge clock); #4;
    n_checks++;
    if ({done, busy} !== 2'b00) $display("FAIL %s_after_done: got done,busy=%b expected 00", name, {done, busy});
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clock); #4;
    n_checks++;
    if ({busy, done, tr_read, vec_valid} !== 4'b0000)
      $display("FAIL reset_ctrl: got busy,done,read,valid=%b expected 0000", {busy, done, tr_read, vec_valid});
    else n_pass++;
    n_checks++;
    if (tr_address !== '0) $display("FAIL reset_addr: got %h expected 00000", tr_address);
    else n_pass++;
    n_checks++;
    if (vec_data !== '0) $display("FAIL reset_vec_data: got %h expected 0000", vec_data);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    #4;
    n_checks++;
    if ({busy, done, tr_read, vec_valid} !== 4'b0000)
      $display("FAIL post_reset_ctrl: got %b expected 0000", {busy, done, tr_read, vec_valid});
    else n_pass++;
    n_checks++;
    if ({tr_write, tr_byteenable, tr_writedata} !== {1'b0, 2'b11, 16'h0000})
      $display("FAIL tie_offs: got write=%b be=%b wdata=%h expected 0 11 0000", tr_write, tr_byteenable, tr_writedata);
    else n_pass++;
  endtask

  task automatic test_basic();
    int dc;
    vec_ready = 1'b1;
    start_fetch(20'h00010, 4);
    finish_fetch("basic", 40, dc);
    n_checks++;
    if (acc_count != 4) $display("FAIL basic_reads: got %0d expected 4", acc_count);
    else n_pass++;
    n_checks++;
    if (first_acc_cyc != start_cyc + 1 || last_acc_cyc != first_acc_cyc + 3)
      $display("FAIL basic_read_cycles: got %0d..%0d expected %0d..%0d", first_acc_cyc, last_acc_cyc, start_cyc + 1, start_cyc + 4);
    else n_pass++;
    n_checks++;
    if (hs_count != 4 || exp_q.size() != 0) $display("FAIL basic_words: got %0d left %0d expected 4 left 0", hs_count, exp_q.size());
    else n_pass++;
    n_checks++;
    if (dc != last_hs_cyc + 1) $display("FAIL basic_done_timing: got cycle %0d expected %0d", dc, last_hs_cyc + 1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int dc;
    vec_ready = 1'b0;
    start_fetch(20'h00100, 20);
    repeat (20) @(negedge clock);
    #4;
    n_checks++;
    if (acc_count != 8) $display("FAIL bp_reads_capped: got %0d expected 8", acc_count);
    else n_pass++;
    n_checks++;
    if ({tr_read, vec_valid, busy} !== 3'b011) $display("FAIL bp_stalled: got read,valid,busy=%b expected 011", {tr_read, vec_valid, busy});
    else n_pass++;
    @(negedge clock);
    vec_ready = 1'b1;
    finish_fetch("bp", 100, dc);
    n_checks++;
    if (acc_count != 20 || hs_count != 20 || exp_q.size() != 0)
      $display("FAIL bp_totals: got reads %0d words %0d left %0d expected 20 20 0", acc_count, hs_count, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dc;
    vec_ready = 1'b1;
    start_fetch(20'h00080, 16);
    // A second start while busy must be ignored.
    start      = 1'b1;
    base_addr  = 20'h55555;
    word_count = CW'(2);
    @(negedge clock);
    start = 1'b0;
    finish_fetch("b2b", 60, dc);
    n_checks++;
    if (acc_count != 16 || hs_count != 16) $display("FAIL b2b_counts: got reads %0d words %0d expected 16 16", acc_count, hs_count);
    else n_pass++;
    n_checks++;
    if (first_hs_cyc != first_acc_cyc + 3 || last_hs_cyc != first_hs_cyc + 15)
      $display("FAIL b2b_throughput: got words at %0d..%0d expected %0d..%0d", first_hs_cyc, last_hs_cyc, first_acc_cyc + 3, first_acc_cyc + 18);
    else n_pass++;
    start_fetch(20'h000A0, 3);
    finish_fetch("b2b_second", 30, dc);
    n_checks++;
    if (hs_count != 3 || exp_q.size() != 0) $display("FAIL b2b_second_words: got %0d left %0d expected 3 0", hs_count, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_stall();
    int dc;
    vec_ready = 1'b1;
    start_fetch(20'h00200, 16);
    for (int i = 0; i < 20 && acc_count < 4; i++) begin
      @(negedge clock); #4;
    end
    @(negedge clock);
    stall_left = 5;
    for (int i = 0; i < 5; i++) begin
      #4;
      n_checks++;
      if ({tr_read, tr_waitrequest} !== 2'b11 || tr_address !== 20'h00204)
        $display("FAIL stall_hold_%0d: got read=%b wait=%b addr=%h expected 1 1 00204", i, tr_read, tr_waitrequest, tr_address);
      else n_pass++;
      @(negedge clock);
    end
    n_checks++;
    if (acc_count != 4) $display("FAIL stall_no_accept: got %0d expected 4", acc_count);
    else n_pass++;
    finish_fetch("stall", 60, dc);
    n_checks++;
    if (acc_count != 16 || hs_count != 16) $display("FAIL stall_totals: got %0d %0d expected 16 16", acc_count, hs_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int dc;
    vec_ready = 1'b1;
    start_fetch(20'hFFFFE, 4);
    finish_fetch("wrap", 40, dc);
    n_checks++;
    if (acc_count != 4 || last_acc_addr !== 20'h00001)
      $display("FAIL wrap_addr: got %0d reads last %h expected 4 last 00001", acc_count, last_acc_addr);
    else n_pass++;
    n_checks++;
    if (hs_count != 4) $display("FAIL wrap_words: got %0d expected 4", hs_count);
    else n_pass++;
  endtask

  task automatic test_abort();
    int dc;
    vec_ready = 1'b0;
    start_fetch(20'h00400, 20);
    for (int i = 0; i < 20 && acc_count < 5; i++) begin
      @(negedge clock); #4;
    end
    // Now 3 words are buffered and 2 reads are in flight.
    @(negedge clock);
    abort = 1'b1;
    exp_q.delete();
    #4;
    n_checks++;
    if (tr_read !== 1'b0 || acc_count != 5 || rsp_count != 4)
      $display("FAIL abort_setup: got read=%b reads %0d returns %0d expected 0 5 4", tr_read, acc_count, rsp_count);
    else n_pass++;
    @(negedge clock);
    abort = 1'b0;
    #4;
    n_checks++;
    if ({vec_valid, busy} !== 2'b01) $display("FAIL abort_flushed: got valid,busy=%b expected 01", {vec_valid, busy});
    else n_pass++;
    finish_fetch("abort", 20, dc);
    @(negedge clock);
    vec_ready = 1'b1;
    repeat (4) @(negedge clock);
    #4;
    n_checks++;
    if (vec_valid !== 1'b0 || hs_count != 0 || rsp_count != 5)
      $display("FAIL abort_late_discard: got valid=%b words %0d returns %0d expected 0 0 5", vec_valid, hs_count, rsp_count);
    else n_pass++;
  endtask

  task automatic test_zero_count();
    vec_ready = 1'b1;
    start_fetch(20'h00123, 0);
    #4;
    n_checks++;
    if ({done, busy, tr_read} !== 3'b100) $display("FAIL zero_done: got done,busy,read=%b expected 100", {done, busy, tr_read});
    else n_pass++;
    @(negedge clock); #4;
    n_checks++;
    if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b expected 0", done);
    else n_pass++;
    repeat (3) @(negedge clock);
    #4;
    n_checks++;
    if (acc_count != 0 || busy !== 1'b0) $display("FAIL zero_no_read: got reads %0d busy %b expected 0 0", acc_count, busy);
    else n_pass++;
  endtask

`ifdef SRAM_VEC_READER_CHECKSUM_EN
  task automatic test_checksum();
    int dc;
    vec_ready = 1'b1;
    start_fetch(20'h00300, 3);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock); #4;
      if (done === 1'b1) break;
    end
    n_checks++;
    if (done !== 1'b1 || checksum !== 16'h0010) $display("FAIL checksum_at_done: got done=%b sum=%h expected 1 0010", done, checksum);
    else n_pass++;
    start_fetch(20'h00000, 0);
    #4;
    n_checks++;
    if (checksum !== 16'h0000) $display("FAIL checksum_clear: got %h expected 0000", checksum);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_midflight();
    int dc;
    vec_ready = 1'b0;
    start_fetch(20'h00500, 12);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    #4;
    n_checks++;
    if ({busy, done, tr_read, vec_valid} !== 4'b0000 || tr_address !== '0 || vec_data !== '0)
      $display("FAIL midflight_reset: got ctrl=%b addr=%h data=%h expected 0000 00000 0000", {busy, done, tr_read, vec_valid}, tr_address, vec_data);
    else n_pass++;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    vec_ready = 1'b1;
    start_fetch(20'h00600, 2);
    finish_fetch("midflight", 30, dc);
    n_checks++;
    if (hs_count != 2 || exp_q.size() != 0) $display("FAIL midflight_recover: got %0d left %0d expected 2 0", hs_count, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_abort();
    test_zero_count();
`ifdef SRAM_VEC_READER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midflight();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected summary before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
